avalon_mem_slave: RTL and testbench

Avalon memory-mapped slave (responder) modelling the CPU's instruction/data memory. It sits on the far end of the `mips_cpu_bus` master port. It serves word reads and byte-enabled writes out of an internal RAM array, and inserts a fixed or pseudo-random number of wait states via `waitrequest`. It also flags out-of-range accesses and master protocol violations so testbenches can catch CPU bus bugs.

---
 rtl/avalon_mem_slave.sv | 186 ++++++++++++++++++
 tb/tb_avalon_mem_slave.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_slave.sv
// avalon_mem_slave: Avalon-MM responder modelling the CPU instruction/data memory.
// Serves word reads and byte-enabled writes from an internal array, inserts
// fixed or LFSR-driven wait states, and raises sticky flags for out-of-window
// accesses and for masters that break the waitrequest handshake.
module avalon_mem_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'hBFC00000,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 1,
    parameter bit          RANDOM_WAIT = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        range_error,
    output logic        protocol_error
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        range_err_q, range_err_d;
    logic        proto_err_q, proto_err_d;

    logic [31:0] mem [DEPTH];

    logic [3:0]    n_wait;
    logic          lfsr_fb;
    logic          done;
    logic [31:0]   eff_addr;
    logic          eff_rd;
    logic          eff_wr;
    logic [31:0]   eff_wdata;
    logic [3:0]    eff_be;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          do_write;

    assign n_wait  = RANDOM_WAIT ? {2'b00, lfsr_q[1:0]} : 4'(WAIT_CYCLES);
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    assign range_error    = range_err_q;
    assign protocol_error = proto_err_q;

    // Handshake FSM, request capture, address decode and completion effects.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        range_err_d = range_err_q;
        proto_err_d = proto_err_q;
        waitrequest = 1'b0;
        done        = 1'b0;
        eff_addr    = address;
        eff_rd      = read;
        eff_wr      = write;
        eff_wdata   = writedata;
        eff_be      = byteenable;

        case (state_q)
            ST_IDLE: begin
                if (read || write) begin
                    if (read && write) begin
                        proto_err_d = 1'b1;
                    end
                    if (n_wait == 4'd0) begin
                        done = 1'b1;
                    end else begin
                        addr_d      = address;
                        rd_d        = read;
                        wr_d        = write;
                        wdata_d     = writedata;
                        be_d        = byteenable;
                        cnt_d       = n_wait - 4'd1;
                        state_d     = ST_WAIT;
                        waitrequest = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                eff_addr  = addr_q;
                eff_rd    = rd_q;
                eff_wr    = wr_q;
                eff_wdata = wdata_q;
                eff_be    = be_q;
                if ((address != addr_q) || (read != rd_q) || (write != wr_q) ||
                    (writedata != wdata_q) || (byteenable != be_q)) begin
                    proto_err_d = 1'b1;
                end
                if (cnt_q != 4'd0) begin
                    waitrequest = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        offset   = eff_addr - ADDR_BASE;
        in_range = (eff_addr >= ADDR_BASE) && (offset < SPAN);
        word_idx = offset[AW+1:2];
        do_write = done && eff_wr && in_range;

        if (done && eff_rd && !eff_wr && in_range) begin
            readdata = mem[word_idx];
        end else begin
            readdata = 32'h0;
        end

        if (done) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
            if (!in_range) begin
                range_err_d = 1'b1;
            end
        end
    end

    // State, latched request, LFSR and sticky flags; reset reseeds and clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            lfsr_q      <= LFSR_SEED;
            addr_q      <= 32'h0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            range_err_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            range_err_q <= range_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Memory array write port; contents survive reset, a write under reset is dropped.
    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_be[i]) begin
                    mem[word_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_slave.sv
// tb_avalon_mem_slave: directed self-checking bench for avalon_mem_slave.
// Four instances cover zero wait states, three, two and LFSR-driven waits.
module tb_avalon_mem_slave;

    logic        clk = 1'b0;
    logic        rst   [4];
    logic [31:0] addr  [4];
    logic        rd    [4];
    logic        wr    [4];
    logic [31:0] wdata [4];
    logic [3:0]  be    [4];
    logic        wreq  [4];
    logic [31:0] rdata [4];
    logic        rerr  [4];
    logic        perr  [4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avalon_mem_slave #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
        .writedata(wdata[0]), .byteenable(be[0]), .waitrequest(wreq[0]),
        .readdata(rdata[0]), .range_error(rerr[0]), .protocol_error(perr[0]));

    avalon_mem_slave #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
        .writedata(wdata[1]), .byteenable(be[1]), .waitrequest(wreq[1]),
        .readdata(rdata[1]), .range_error(rerr[1]), .protocol_error(perr[1]));

    avalon_mem_slave #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(rst[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
        .writedata(wdata[2]), .byteenable(be[2]), .waitrequest(wreq[2]),
        .readdata(rdata[2]), .range_error(rerr[2]), .protocol_error(perr[2]));

    avalon_mem_slave #(.RANDOM_WAIT(1'b1), .LFSR_SEED(16'hACE1)) u_rnd (
        .clk(clk), .reset(rst[3]), .address(addr[3]), .read(rd[3]), .write(wr[3]),
        .writedata(wdata[3]), .byteenable(be[3]), .waitrequest(wreq[3]),
        .readdata(rdata[3]), .range_error(rerr[3]), .protocol_error(perr[3]));

    // Reference 16-bit Fibonacci LFSR step, taps 16,14,13,11 (right-shifting form).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int x;
        int b;
        x = int'(v);
        b = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
        return 16'((x >> 1) | (b << 15));
    endfunction

    // Bus master: present one transfer, hold it through waitrequest, return data and stall count.
    task automatic xfer(input int k, input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] data, output int stalls);
        bit fin;
        addr[k] = a; rd[k] = r; wr[k] = w; wdata[k] = d; be[k] = b;
        stalls = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (!wreq[k]) begin
                fin = 1'b1;
            end else begin
                stalls++;
                if (stalls > 40) begin
                    n_assert++; n_fail++;
                    $display("[TB] FAIL xfer_timeout inst=%0d: waitrequest high %0d cycles, required low", k, stalls);
                    fin = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        data = rdata[k];
        @(posedge clk); #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) rst[k] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_assert++;
            if (wreq[k] !== 1'b0 || rdata[k] !== 32'h0 || rerr[k] !== 1'b0 || perr[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_state inst=%0d: wreq=%b rdata=%h rerr=%b perr=%b, required 0/0/0/0",
                         k, wreq[k], rdata[k], rerr[k], perr[k]);
            end
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] d;
        int s;
        @(posedge clk); #1;
        xfer(0, 32'hBFC00010, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, d, s);
        n_assert++;
        if (s !== 0) begin n_fail++; $display("[TB] FAIL w0_write_stalls: got %0d, required 0", s); end
        xfer(0, 32'hBFC00010, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (s !== 0) begin n_fail++; $display("[TB] FAIL w0_read_stalls: got %0d, required 0", s); end
        n_assert++;
        if (d !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL w0_read_data: got %h, required deadbeef", d); end
        @(negedge clk);
        n_assert++;
        if (rdata[0] !== 32'h0) begin n_fail++; $display("[TB] FAIL w0_idle_rdata: got %h, required 0", rdata[0]); end
    endtask

    task automatic test_wait_states();
        logic [31:0] d;
        int s;
        logic exp_w;
        logic [31:0] exp_d;
        @(posedge clk); #1;
        xfer(1, 32'hBFC00000, 1'b0, 1'b1, 32'h24020005, 4'hF, d, s);
        n_assert++;
        if (s !== 3) begin n_fail++; $display("[TB] FAIL w3_write_stalls: got %0d, required 3", s); end
        addr[1] = 32'hBFC00000; rd[1] = 1'b1; wr[1] = 1'b0; be[1] = 4'h0; wdata[1] = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_w = (c < 3);
            exp_d = (c == 3) ? 32'h24020005 : 32'h0;
            n_assert++;
            if (wreq[1] !== exp_w || rdata[1] !== exp_d) begin
                n_fail++;
                $display("[TB] FAIL w3_read_cycle%0d: wreq=%b rdata=%h, required %b/%h", c, wreq[1], rdata[1], exp_w, exp_d);
            end
            @(posedge clk); #1;
        end
        rd[1] = 1'b0;
        @(negedge clk);
        n_assert++;
        if (wreq[1] !== 1'b0 || rdata[1] !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL w3_after_read: wreq=%b rdata=%h, required 0/0", wreq[1], rdata[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int s;
        @(posedge clk); #1;
        xfer(1, 32'hBFC00004, 1'b0, 1'b1, 32'h0BADF00D, 4'hF, d, s);
        xfer(1, 32'hBFC00004, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (s !== 3 || d !== 32'h0BADF00D) begin
            n_fail++;
            $display("[TB] FAIL w3_back_to_back: stalls=%0d data=%h, required 3/0badf00d", s, d);
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] d;
        int s;
        @(posedge clk); #1;
        xfer(0, 32'hBFC00020, 1'b0, 1'b1, 32'h11223344, 4'hF, d, s);
        xfer(0, 32'hBFC00020, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101, d, s);
        xfer(0, 32'hBFC00020, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (d !== 32'h11BB33DD) begin n_fail++; $display("[TB] FAIL be_0101: got %h, required 11bb33dd", d); end
        xfer(0, 32'hBFC00020, 1'b0, 1'b1, 32'h00000000, 4'h0, d, s);
        xfer(0, 32'hBFC00020, 1'b1, 1'b0, 32'h0, 4'hF, d, s);
        n_assert++;
        if (d !== 32'h11BB33DD) begin n_fail++; $display("[TB] FAIL be_zero: got %h, required 11bb33dd", d); end
        xfer(0, 32'hBFC00020, 1'b0, 1'b1, 32'hEEFF0099, 4'b1010, d, s);
        xfer(0, 32'hBFC00020, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (d !== 32'hEEBB00DD) begin n_fail++; $display("[TB] FAIL be_1010: got %h, required eebb00dd", d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        int s;
        @(posedge clk); #1;
        xfer(0, 32'hBFC00000, 1'b0, 1'b1, 32'h55AA55AA, 4'hF, d, s);
        xfer(0, 32'hBFC03FFC, 1'b0, 1'b1, 32'h77777777, 4'hF, d, s);
        xfer(0, 32'hBFC03FFC, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (d !== 32'h77777777 || rerr[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL oor_last_word: data=%h rerr=%b, required 77777777/0", d, rerr[0]);
        end
        xfer(0, 32'h00000000, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (s !== 0 || d !== 32'h0 || rerr[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL oor_read_low: stalls=%0d data=%h rerr=%b, required 0/0/1", s, d, rerr[0]);
        end
        xfer(0, 32'hBFC04000, 1'b0, 1'b1, 32'h12345678, 4'hF, d, s);
        n_assert++;
        if (s !== 0) begin n_fail++; $display("[TB] FAIL oor_write_stalls: got %0d, required 0", s); end
        xfer(0, 32'hBFC00000, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (d !== 32'h55AA55AA) begin n_fail++; $display("[TB] FAIL oor_write_dropped: got %h, required 55aa55aa", d); end
        xfer(0, 32'hBFBFFFFC, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL oor_below_base: got %h, required 0", d); end
        @(negedge clk);
        n_assert++;
        if (rerr[0] !== 1'b1 || perr[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL oor_sticky: rerr=%b perr=%b, required 1/0", rerr[0], perr[0]);
        end
    endtask

    task automatic test_protocol();
        logic [31:0] d;
        int s;
        @(posedge clk); #1;
        xfer(2, 32'hBFC00040, 1'b0, 1'b1, 32'hA1A1A1A1, 4'hF, d, s);
        n_assert++;
        if (s !== 2) begin n_fail++; $display("[TB] FAIL w2_write_stalls: got %0d, required 2", s); end
        xfer(2, 32'hBFC00044, 1'b0, 1'b1, 32'hB2B2B2B2, 4'hF, d, s);
        n_assert++;
        if (perr[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL proto_clean: perr=%b, required 0", perr[2]); end
        addr[2] = 32'hBFC00040; rd[2] = 1'b1; wr[2] = 1'b0; be[2] = 4'h0; wdata[2] = 32'h0;
        @(posedge clk); #1;
        addr[2] = 32'hBFC00044;
        @(posedge clk); #1;
        @(negedge clk);
        n_assert++;
        if (wreq[2] !== 1'b0 || rdata[2] !== 32'hA1A1A1A1) begin
            n_fail++;
            $display("[TB] FAIL proto_latched_read: wreq=%b rdata=%h, required 0/a1a1a1a1", wreq[2], rdata[2]);
        end
        @(posedge clk); #1;
        rd[2] = 1'b0;
        @(negedge clk);
        n_assert++;
        if (perr[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL proto_addr_change: perr=%b, required 1", perr[2]); end
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        @(negedge clk);
        n_assert++;
        if (perr[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL proto_reset_clear: perr=%b, required 0", perr[2]); end
        @(posedge clk); #1;
        xfer(2, 32'hBFC00048, 1'b1, 1'b1, 32'hC3C3C3C3, 4'hF, d, s);
        n_assert++;
        if (s !== 2 || d !== 32'h0 || perr[2] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL proto_rd_and_wr: stalls=%0d data=%h perr=%b, required 2/0/1", s, d, perr[2]);
        end
        xfer(2, 32'hBFC00048, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (d !== 32'hC3C3C3C3) begin n_fail++; $display("[TB] FAIL proto_rd_and_wr_data: got %h, required c3c3c3c3", d); end
    endtask

    task automatic test_random_wait();
        logic [31:0] d;
        int s;
        int max_s;
        bit found;
        logic [15:0] lf;
        rst[3] = 1'b1;
        @(posedge clk); #1;
        rst[3] = 1'b0;
        lf = 16'hACE1;
        max_s = 0;
        for (int i = 0; i < 100; i++) begin
            xfer(3, 32'hBFC00000 + 32'(4 * (i % 8)), 1'b1, 1'b0, 32'h0, 4'h0, d, s);
            n_assert++;
            if (s !== int'(lf[1:0])) begin
                n_fail++;
                $display("[TB] FAIL rnd_stall[%0d]: got %0d, required %0d", i, s, lf[1:0]);
            end
            if (s > max_s) max_s = s;
            lf = lfsr_next(lf);
        end
        n_assert++;
        if (max_s > 3 || perr[3] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rnd_bounds: max stall=%0d perr=%b, required <=3/0", max_s, perr[3]);
        end
        xfer(3, 32'hBFC00100, 1'b0, 1'b1, 32'h600DCAFE, 4'hF, d, s);
        n_assert++;
        if (s !== int'(lf[1:0])) begin n_fail++; $display("[TB] FAIL rnd_write_stall: got %0d, required %0d", s, lf[1:0]); end
        lf = lfsr_next(lf);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (lf[1:0] >= 2'd2) begin
                found = 1'b1;
            end else begin
                xfer(3, 32'hBFC00000, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
                lf = lfsr_next(lf);
            end
        end
        n_assert++;
        if (!found) begin n_fail++; $display("[TB] FAIL rnd_find_long_wait: no stall>=2 in 30 steps, required one"); end
        addr[3] = 32'hBFC00100; rd[3] = 1'b0; wr[3] = 1'b1; wdata[3] = 32'h0BAD0BAD; be[3] = 4'hF;
        @(negedge clk);
        n_assert++;
        if (wreq[3] !== 1'b1) begin n_fail++; $display("[TB] FAIL rnd_midwait_accept: wreq=%b, required 1", wreq[3]); end
        @(posedge clk); #1;
        rst[3] = 1'b1; wr[3] = 1'b0;
        @(posedge clk); #1;
        rst[3] = 1'b0;
        @(negedge clk);
        n_assert++;
        if (wreq[3] !== 1'b0 || perr[3] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rnd_midwait_reset: wreq=%b perr=%b, required 0/0", wreq[3], perr[3]);
        end
        @(posedge clk); #1;
        lf = 16'hACE1;
        xfer(3, 32'hBFC00100, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
        n_assert++;
        if (s !== int'(lf[1:0]) || d !== 32'h600DCAFE) begin
            n_fail++;
            $display("[TB] FAIL rnd_reseed_first: stalls=%0d data=%h, required %0d/600dcafe", s, d, lf[1:0]);
        end
        lf = lfsr_next(lf);
        for (int i = 0; i < 5; i++) begin
            xfer(3, 32'hBFC00000, 1'b1, 1'b0, 32'h0, 4'h0, d, s);
            n_assert++;
            if (s !== int'(lf[1:0])) begin
                n_fail++;
                $display("[TB] FAIL rnd_reseed_stall[%0d]: got %0d, required %0d", i, s, lf[1:0]);
            end
            lf = lfsr_next(lf);
        end
    endtask

    // Run all scenarios in order and print the summary.
    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; addr[k] = 32'h0; rd[k] = 1'b0; wr[k] = 1'b0;
            wdata[k] = 32'h0; be[k] = 4'h0;
        end
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_back_to_back();
        test_byte_enables();
        test_out_of_range();
        test_protocol();
        test_random_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit so a stuck handshake cannot hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
